pwm_multi_ramp: RTL and testbench

- Multi-channel successor to the single-motor PWM/IHM pair.
- Drives CHANNELS independent PWM outputs from one shared period counter.
- Each channel has its own target duty (0-100 %), start/stop state and soft-start/soft-stop ramping.
- Consumes the debounced switch levels from the controller block; feeds binary_to_digits/display with the selected channel's target duty.

---
 rtl/pwm_multi_ramp_if.sv | 45 ++++
 rtl/pwm_multi_ramp.sv | 230 +++++++++++++++++++++++
 tb/tb_pwm_multi_ramp.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_ramp_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_ramp_if
// Bundle between the switch/display side (master) and the multi-channel PWM
// block (slave).
//
// Signals:
//   sel            : channel addressed by switch events (master -> slave)
//   swt_increase   : debounced switch level, rising edge = target +STEP
//   swt_decrease   : debounced switch level, rising edge = target -STEP
//   swt_start_stop : debounced switch level, rising edge = start/stop toggle
//   pwm_out        : one PWM output per channel (slave -> master)
//   running        : 1 per channel whose state is not IDLE
//   duty_sel       : target duty of sel, 0-100
//   duty_act_sel   : actual (ramped) duty of sel, 0-100
//   state_dbg      : 2 bits per channel, raw FSM state
//
// Handshake: there is no valid/ready pair. The switch inputs are levels; the
// slave registers them and acts on a 0->1 transition exactly once, in the
// cycle it is seen. Outputs are free-running registered values.
// ---------------------------------------------------------------------------
interface pwm_multi_ramp_if #(
    parameter int CHANNELS = 4
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SW-1:0]         sel;
    logic                  swt_increase;
    logic                  swt_decrease;
    logic                  swt_start_stop;
    logic [CHANNELS-1:0]   pwm_out;
    logic [CHANNELS-1:0]   running;
    logic [6:0]            duty_sel;
    logic [6:0]            duty_act_sel;
    logic [2*CHANNELS-1:0] state_dbg;

    modport master (
        output sel, swt_increase, swt_decrease, swt_start_stop,
        input  pwm_out, running, duty_sel, duty_act_sel, state_dbg
    );

    modport slave (
        input  sel, swt_increase, swt_decrease, swt_start_stop,
        output pwm_out, running, duty_sel, duty_act_sel, state_dbg
    );
endinterface

// File: rtl/pwm_multi_ramp.sv
// ---------------------------------------------------------------------------
// pwm_multi_ramp
// CHANNELS independent PWM outputs sharing one 0..99 period counter. Each
// channel has a target duty edited by inc/dec switch events, and an actual
// duty that ramps 1 % per ramp tick toward the target (soft start) or down
// to 0 (soft stop).
//
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : pwm_multi_ramp_if.slave (switch levels in, PWM/status out)
//
// Channel FSM state encoding (also on bus.state_dbg, 2 bits per channel):
//   0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
// ---------------------------------------------------------------------------
module pwm_multi_ramp #(
    parameter int CHANNELS     = 4,
    parameter int PRESCALE     = 500,
    parameter int RAMP_TICKS   = 5000,
    parameter int STEP         = 10,
    parameter int DEFAULT_DUTY = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_multi_ramp_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    // ---------------- edge detection ----------------
    logic inc_q, dec_q, ss_q;
    logic inc_ev, dec_ev, ss_ev;
    logic sel_ok;

    assign inc_ev = bus.swt_increase   & ~inc_q;
    assign dec_ev = bus.swt_decrease   & ~dec_q;
    assign ss_ev  = bus.swt_start_stop & ~ss_q;
    assign sel_ok = (int'(bus.sel) < CHANNELS);

    // Reset loads the live levels so a switch held through reset is not an event.
    always_ff @(posedge clk) begin
        inc_q <= bus.swt_increase;
        dec_q <= bus.swt_decrease;
        ss_q  <= bus.swt_start_stop;
    end

    // ---------------- shared timebases ----------------
    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] ramp_cnt;
    logic [6:0]    period_cnt;
    logic          pre_tick, ramp_tick, period_wrap;

    assign pre_tick    = (pre_cnt == PW'(PRESCALE - 1));
    assign ramp_tick   = (ramp_cnt == RW'(RAMP_TICKS - 1));
    assign period_wrap = pre_tick && (period_cnt == 7'd99);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            ramp_cnt   <= '0;
            period_cnt <= '0;
        end else begin
            pre_cnt  <= pre_tick  ? '0 : pre_cnt + 1'b1;
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
            if (pre_tick) begin
                period_cnt <= period_wrap ? 7'd0 : period_cnt + 7'd1;
            end
        end
    end

    // ---------------- per-channel state ----------------
    state_t              state_q   [CHANNELS];
    state_t              state_d   [CHANNELS];
    logic   [6:0]        target_q  [CHANNELS];
    logic   [6:0]        target_d  [CHANNELS];
    logic   [6:0]        actual_q  [CHANNELS];
    logic   [6:0]        actual_d  [CHANNELS];
    logic   [6:0]        cmp_q     [CHANNELS];
    logic   [CHANNELS-1:0] hit, ss_hit, inc_hit, dec_hit;
    logic   [CHANNELS-1:0] ramp_up_en, ramp_dn_en, idle_clr, running_c;
    logic   [CHANNELS-1:0] pwm_q;
    logic   [6:0]        duty_sel_q, duty_act_q;
    logic   [6:0]        sel_target, sel_actual;

    // Event decode: simultaneous inc and dec cancel each other.
    always_comb begin
        hit     = '0;
        ss_hit  = '0;
        inc_hit = '0;
        dec_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]     = sel_ok && (int'(bus.sel) == i);
            ss_hit[i]  = hit[i] && ss_ev;
            inc_hit[i] = hit[i] && inc_ev && !dec_ev;
            dec_hit[i] = hit[i] && dec_ev && !inc_ev;
        end
    end

    // Saturating target arithmetic, editable in every state.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target_d[i] = target_q[i];
            if (inc_hit[i]) begin
                target_d[i] = (target_q[i] > 7'(100 - STEP)) ? 7'd100
                                                            : target_q[i] + 7'(STEP);
            end else if (dec_hit[i]) begin
                target_d[i] = (target_q[i] < 7'(STEP)) ? 7'd0
                                                      : target_q[i] - 7'(STEP);
            end
        end
    end

    // FSM process 1: state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst_n) state_q[i] <= S_IDLE;
            else        state_q[i] <= state_d[i];
        end
    end

    // FSM process 2: next state. start/stop has priority over settle checks.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (ss_hit[i]) state_d[i] = S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    if (ss_hit[i])                       state_d[i] = S_RAMP_DOWN;
                    else if (actual_q[i] == target_q[i]) state_d[i] = S_RUN;
                end
                S_RUN: begin
                    if (ss_hit[i])                       state_d[i] = S_RAMP_DOWN;
                    else if (actual_q[i] != target_q[i]) state_d[i] = S_RAMP_UP;
                end
                S_RAMP_DOWN: begin
                    if (ss_hit[i])                state_d[i] = S_RAMP_UP;
                    else if (actual_q[i] == 7'd0) state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // FSM process 3: outputs / datapath controls decoded from state.
    always_comb begin
        ramp_up_en = '0;
        ramp_dn_en = '0;
        idle_clr   = '0;
        running_c  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ramp_up_en[i] = (state_q[i] == S_RAMP_UP);
            ramp_dn_en[i] = (state_q[i] == S_RAMP_DOWN);
            idle_clr[i]   = (state_q[i] == S_IDLE);
            running_c[i]  = (state_q[i] != S_IDLE);
        end
    end

    // Actual duty: RAMP_UP tracks the target in either direction.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            actual_d[i] = actual_q[i];
            if (idle_clr[i]) begin
                actual_d[i] = 7'd0;
            end else if (ramp_up_en[i] && ramp_tick) begin
                if (actual_q[i] < target_q[i])      actual_d[i] = actual_q[i] + 7'd1;
                else if (actual_q[i] > target_q[i]) actual_d[i] = actual_q[i] - 7'd1;
            end else if (ramp_dn_en[i] && ramp_tick && (actual_q[i] != 7'd0)) begin
                actual_d[i] = actual_q[i] - 7'd1;
            end
        end
    end

    // Selected-channel readback uses next-state values so an event shows on
    // the registered outputs right after the edge that consumed it.
    always_comb begin
        sel_target = 7'd0;
        sel_actual = 7'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) begin
                sel_target = target_d[i];
                sel_actual = actual_d[i];
            end
        end
    end

    // Datapath registers. The compare value only reloads at the period wrap
    // so a duty change never produces a truncated or stretched pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= 7'(DEFAULT_DUTY);
                actual_q[i] <= 7'd0;
                cmp_q[i]    <= 7'd0;
            end
            pwm_q      <= '0;
            duty_sel_q <= 7'(DEFAULT_DUTY);
            duty_act_q <= 7'd0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= target_d[i];
                actual_q[i] <= actual_d[i];
                if (period_wrap) cmp_q[i] <= actual_q[i];
                pwm_q[i] <= (period_cnt < cmp_q[i]);
            end
            duty_sel_q <= sel_target;
            duty_act_q <= sel_actual;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.running      = running_c;
    assign bus.duty_sel     = duty_sel_q;
    assign bus.duty_act_sel = duty_act_q;

    always_comb begin
        bus.state_dbg = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.state_dbg[2*i +: 2] = state_q[i];
        end
    end
endmodule

// File: tb/tb_pwm_multi_ramp.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_ramp
// Directed bench for pwm_multi_ramp with CHANNELS=2, PRESCALE=1,
// RAMP_TICKS=4, STEP=10, DEFAULT_DUTY=50. Expected values are queued when
// the stimulus is driven and popped when the corresponding output is read.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pwm_multi_ramp;
    localparam int CH = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_ramp_if #(.CHANNELS(CH)) bus ();

    pwm_multi_ramp #(
        .CHANNELS     (CH),
        .PRESCALE     (1),
        .RAMP_TICKS   (4),
        .STEP         (10),
        .DEFAULT_DUTY (50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: observed %0d with no expected value", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle high pulse on the chosen switches, then one cycle low.
    task automatic pulse(input bit inc, input bit dec, input bit ss);
        bus.swt_increase   = inc;
        bus.swt_decrease   = dec;
        bus.swt_start_stop = ss;
        @(negedge clk);
        bus.swt_increase   = 1'b0;
        bus.swt_decrease   = 1'b0;
        bus.swt_start_stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_act(input logic [6:0] v, input int bound, output int n);
        n = 0;
        while (bus.duty_act_sel !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_high(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (100) begin
            @(negedge clk);
            c0 += int'(bus.pwm_out[0]);
            c1 += int'(bus.pwm_out[1]);
        end
    endtask

    // ---------------- directed sequence ----------------
    int n, c0, c1;
    logic [6:0] mn;

    initial begin
        bus.sel            = '0;
        bus.swt_increase   = 1'b0;
        bus.swt_decrease   = 1'b0;
        bus.swt_start_stop = 1'b1;   // held through reset: must not start
        rst_n              = 1'b0;
        expect_val("reset_running", 32'd0);
        expect_val("reset_pwm", 32'd0);
        expect_val("reset_duty_sel", 32'd50);
        expect_val("reset_duty_act", 32'd0);
        expect_val("reset_state", 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        bus.swt_start_stop = 1'b0;
        cyc(2);
        check_obs(32'(bus.running));
        check_obs(32'(bus.pwm_out));
        check_obs(32'(bus.duty_sel));
        check_obs(32'(bus.duty_act_sel));
        check_obs(32'(bus.state_dbg));

        // Channel 0 soft start to 50 %.
        bus.sel = 1'b0;
        expect_val("ch0_start_running", 32'd1);
        expect_val("ch0_start_state", 32'd1);
        pulse(0, 0, 1);
        check_obs(32'(bus.running));
        check_obs(32'(bus.state_dbg[1:0]));
        expect_val("ch0_ramp_final", 32'd50);
        expect_val("ch0_ramp_time", 32'd1);
        wait_act(7'd50, 300, n);
        check_obs(32'(bus.duty_act_sel));
        check_obs({31'd0, (n >= 190 && n <= 210)});
        expect_val("ch0_run_state", 32'd2);
        cyc(2);
        check_obs(32'(bus.state_dbg[1:0]));
        expect_val("ch0_pwm_50", 32'd50);
        expect_val("ch1_pwm_idle", 32'd0);
        cyc(110);
        count_high(c0, c1);
        check_obs(32'(c0));
        check_obs(32'(c1));

        // Channel 1: target saturates at 100, then start.
        bus.sel = 1'b1;
        expect_val("ch1_inc5", 32'd100);
        repeat (5) pulse(1, 0, 0);
        check_obs(32'(bus.duty_sel));
        expect_val("ch1_inc6_sat", 32'd100);
        expect_val("ch1_idle_state", 32'd0);
        expect_val("ch0_undisturbed", 32'd2);
        pulse(1, 0, 0);
        check_obs(32'(bus.duty_sel));
        check_obs(32'(bus.state_dbg[3:2]));
        check_obs(32'(bus.state_dbg[1:0]));
        expect_val("ch1_ramp_final", 32'd100);
        pulse(0, 0, 1);
        wait_act(7'd100, 500, n);
        check_obs(32'(bus.duty_act_sel));
        expect_val("ch0_pwm_still_50", 32'd50);
        expect_val("ch1_pwm_100", 32'd100);
        expect_val("both_running", 32'd3);
        cyc(110);
        count_high(c0, c1);
        check_obs(32'(c0));
        check_obs(32'(c1));
        check_obs(32'(bus.running));

        // Channel 0 target to 0: stays running at 0 %.
        bus.sel = 1'b0;
        expect_val("ch0_dec_sat", 32'd0);
        repeat (6) pulse(0, 1, 0);
        check_obs(32'(bus.duty_sel));
        expect_val("ch0_act_zero", 32'd0);
        wait_act(7'd0, 300, n);
        check_obs(32'(bus.duty_act_sel));
        expect_val("ch0_run_at_0", 32'd2);
        expect_val("ch0_running_at_0", 32'd3);
        cyc(2);
        check_obs(32'(bus.state_dbg[1:0]));
        check_obs(32'(bus.running));
        expect_val("ch0_pwm_0", 32'd0);
        expect_val("ch1_pwm_still_100", 32'd100);
        cyc(110);
        count_high(c0, c1);
        check_obs(32'(c0));
        check_obs(32'(c1));

        // Simultaneous inc+dec edges cancel.
        bus.sel = 1'b1;
        expect_val("ch1_incdec", 32'd100);
        pulse(1, 1, 0);
        check_obs(32'(bus.duty_sel));
        bus.sel = 1'b0;
        expect_val("ch0_inc_10", 32'd10);
        pulse(1, 0, 0);
        check_obs(32'(bus.duty_sel));
        expect_val("ch0_incdec", 32'd10);
        pulse(1, 1, 0);
        check_obs(32'(bus.duty_sel));
        expect_val("ch0_back_50", 32'd50);
        repeat (4) pulse(1, 0, 0);
        check_obs(32'(bus.duty_sel));
        expect_val("ch0_act_50_again", 32'd50);
        wait_act(7'd50, 300, n);
        check_obs(32'(bus.duty_act_sel));
        cyc(2);

        // Reverse a soft stop at 30 % back to 50 %.
        expect_val("ch0_ramp_down_state", 32'd3);
        pulse(0, 0, 1);
        check_obs(32'(bus.state_dbg[1:0]));
        expect_val("ch0_down_30", 32'd30);
        wait_act(7'd30, 200, n);
        check_obs(32'(bus.duty_act_sel));
        expect_val("ch0_reversed_state", 32'd1);
        mn = bus.duty_act_sel;
        pulse(0, 0, 1);
        check_obs(32'(bus.state_dbg[1:0]));
        n = 0;
        while (bus.duty_act_sel !== 7'd50 && n < 200) begin
            if (bus.duty_act_sel < mn) mn = bus.duty_act_sel;
            @(negedge clk);
            n++;
        end
        expect_val("ch0_climb_50", 32'd50);
        expect_val("ch0_min_near_30", 32'd1);
        check_obs(32'(bus.duty_act_sel));
        check_obs({31'd0, (mn >= 7'd28 && mn <= 7'd30)});

        // Reset in the middle of a ramp down, with sel moved to channel 1.
        cyc(2);
        pulse(0, 0, 1);
        wait_act(7'd40, 200, n);
        expect_val("midreset_running", 32'd0);
        expect_val("midreset_pwm", 32'd0);
        expect_val("midreset_duty_sel", 32'd50);
        expect_val("midreset_duty_act", 32'd0);
        expect_val("midreset_state", 32'd0);
        bus.sel = 1'b1;
        rst_n   = 1'b0;
        @(negedge clk);
        check_obs(32'(bus.running));
        check_obs(32'(bus.pwm_out));
        check_obs(32'(bus.duty_sel));
        check_obs(32'(bus.duty_act_sel));
        check_obs(32'(bus.state_dbg));
        rst_n = 1'b1;
        cyc(2);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d expected values never compared", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
